// File: rtl/acc_operand_feeder.sv
// Operand/clear feeder in front of the 16-bit accumulator: buffers entries in an
// in-order FIFO and issues at most one registered operand or clear strobe per clock.
module acc_operand_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,   // power of 2, >= 2
    parameter int ADDR_W = 2    // log2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              acc_ready,
    output logic [DATA_W-1:0] IOIn,
    output logic              acc_load,
    output logic              acc_clear,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];

    // Handshake: an entry transfers on a rising edge where in_valid && in_ready;
    // the source must hold in_data/in_clear stable until that edge. in_ready
    // depends on occupancy only, never on in_valid.
    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && acc_ready;
    assign head     = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {in_clear, in_data};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            IOIn      <= '0;
            acc_load  <= 1'b0;
            acc_clear <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Strobes are single-cycle; IOIn holds its last value between issues.
            acc_load  <= pop && !head[DATA_W];
            acc_clear <= pop &&  head[DATA_W];
            if (pop) begin
                IOIn <= head[DATA_W] ? '0 : head[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_acc_operand_feeder.sv
// Directed bench for acc_operand_feeder: cycle table for latency/fill/clear ordering,
// then async reset, steady push+pop at count 2, and a toggled-ready random stream.
module tb_acc_operand_feeder;

    logic        CLK;
    logic        reset;
    logic [15:0] in_data;
    logic        in_clear;
    logic        in_valid;
    logic        in_ready;
    logic        acc_ready;
    logic [15:0] IOIn;
    logic        acc_load;
    logic        acc_clear;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    acc_operand_feeder #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_data   (in_data),
        .in_clear  (in_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_ready (acc_ready),
        .IOIn      (IOIn),
        .acc_load  (acc_load),
        .acc_clear (acc_clear),
        .count     (count)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic clr, input logic v, input logic r);
        in_data   = d;
        in_clear  = clr;
        in_valid  = v;
        acc_ready = r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [15:0] d;
        logic        clr;
        logic        v;
        logic        r;
        logic [15:0] e_io;
        logic        e_ld;
        logic        e_cl;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vt[20];

    logic [15:0] exp_q[$];
    logic [15:0] stream[20];
    logic [15:0] exp_w;
    logic        accepted;
    logic        prev_r;
    int          idx;
    int          issued;
    int          budget;

    initial begin
        // Inputs applied before an edge; expected outputs right after it.
        vt[0]  = '{16'hFF00, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1};
        vt[1]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'hFF00, 1'b1, 1'b0, 3'd0, 1'b1};
        vt[2]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[3]  = '{16'h0001, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd1, 1'b1};
        vt[4]  = '{16'h0002, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd2, 1'b1};
        vt[5]  = '{16'h0003, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd3, 1'b1};
        vt[6]  = '{16'h0004, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd4, 1'b0};
        vt[7]  = '{16'h0005, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd4, 1'b0};
        vt[8]  = '{16'h0005, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 3'd4, 1'b0};
        vt[9]  = '{16'h0005, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 3'd3, 1'b1};
        vt[10] = '{16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 3'd3, 1'b1};
        vt[11] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 3'd2, 1'b1};
        vt[12] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 3'd1, 1'b1};
        vt[13] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 3'd0, 1'b1};
        vt[14] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[15] = '{16'h0010, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 3'd1, 1'b1};
        vt[16] = '{16'h1234, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 3'd1, 1'b1};
        vt[17] = '{16'h0020, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b1};
        vt[18] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 3'd0, 1'b1};
        vt[19] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 3'd0, 1'b1};

        // Reset held low, then released
        reset = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("rst_ioin", IOIn, 16'h0000);
        check("rst_load", acc_load, 1'b0);
        check("rst_clear", acc_clear, 1'b0);
        check("rst_count", count, 3'd0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_count", count, 3'd0);

        // Latency, fill/stall, clear ordering
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].d, vt[i].clr, vt[i].v, vt[i].r);
            tick();
            check($sformatf("vec%0d_ioin", i), IOIn, vt[i].e_io);
            check($sformatf("vec%0d_load", i), acc_load, vt[i].e_ld);
            check($sformatf("vec%0d_clear", i), acc_clear, vt[i].e_cl);
            check($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
            check($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_rdy);
        end

        // Asynchronous reset of a half-full FIFO, away from any edge
        drive(16'h1111, 1'b0, 1'b1, 1'b0);
        tick();
        drive(16'h2222, 1'b0, 1'b1, 1'b0);
        tick();
        check("half_count", count, 3'd2);
        drive(16'h0000, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", count, 3'd0);
        check("async_ioin", IOIn, 16'h0000);
        check("async_in_ready", in_ready, 1'b1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst%0d_load", i), acc_load, 1'b0);
            check($sformatf("post_rst%0d_clear", i), acc_clear, 1'b0);
            check($sformatf("post_rst%0d_count", i), count, 3'd0);
        end

        // Steady push+pop at count 2 for 10 cycles, crossing the pointer wrap
        drive(16'h0A0A, 1'b0, 1'b1, 1'b0);
        tick();
        drive(16'h0B0B, 1'b0, 1'b1, 1'b0);
        tick();
        check("steady_fill_count", count, 3'd2);
        exp_q = {};
        exp_q.push_back(16'h0A0A);
        exp_q.push_back(16'h0B0B);
        for (int k = 0; k < 10; k++) begin
            drive(16'hC000 + 16'(k), 1'b0, 1'b1, 1'b1);
            exp_q.push_back(16'hC000 + 16'(k));
            tick();
            exp_w = exp_q.pop_front();
            check($sformatf("steady%0d_ioin", k), IOIn, exp_w);
            check($sformatf("steady%0d_load", k), acc_load, 1'b1);
            check($sformatf("steady%0d_count", k), count, 3'd2);
        end
        drive(16'h0000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_w = exp_q.pop_front();
            check($sformatf("steady_drain%0d_ioin", k), IOIn, exp_w);
            check($sformatf("steady_drain%0d_load", k), acc_load, 1'b1);
        end
        tick();
        check("steady_end_count", count, 3'd0);
        check("steady_end_load", acc_load, 1'b0);

        // Random stream with acc_ready toggling every cycle
        foreach (stream[i]) stream[i] = 16'($urandom_range(0, 16'hFFFF));
        exp_q = {};
        idx = 0;
        issued = 0;
        budget = 0;
        acc_ready = 1'b0;
        while ((idx < 20 || exp_q.size() != 0) && budget < 200) begin
            acc_ready = ~acc_ready;
            in_clear  = 1'b0;
            in_valid  = (idx < 20);
            in_data   = (idx < 20) ? stream[idx] : 16'h0000;
            #1;
            accepted = in_valid && in_ready;
            prev_r   = acc_ready;
            @(posedge CLK);
            #1;
            if (accepted) begin
                exp_q.push_back(stream[idx]);
                idx++;
            end
            if (acc_load && acc_clear)
                check("rand_both_strobes", 1'b1, 1'b0);
            if (acc_load || acc_clear) begin
                check("rand_ready_at_issue", prev_r, 1'b1);
                check("rand_kind", acc_load, 1'b1);
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_issue", 1'b1, 1'b0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check($sformatf("rand_word%0d", issued), IOIn, exp_w);
                end
                issued++;
            end
            budget++;
        end
        check("rand_budget", (budget < 200) ? 1'b1 : 1'b0, 1'b1);
        check("rand_issued", issued, 20);
        in_valid = 1'b0;
        acc_ready = 1'b1;
        tick();
        check("rand_end_count", count, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
